// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - state encoding, note divisors and melody contents for the note scheduler
package note_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_GAP   = 2'd2,
    ST_PAUSE = 2'd3
  } seq_state_t;

  localparam int ROM_DEPTH = 16;

  // Each entry is {code[2:0], beats[2:0]}, written in octal so the two digits read as code/beats.
  localparam logic [5:0] MELODY [0:ROM_DEPTH-1] = '{
    6'o31, 6'o21, 6'o11, 6'o21, 6'o31, 6'o31, 6'o32, 6'o01,
    6'o21, 6'o21, 6'o22, 6'o01, 6'o31, 6'o51, 6'o52, 6'o01
  };

  function automatic logic [19:0] note_divisor(input logic [2:0] code);
    case (code)
      3'd1:    return 20'd76628;
      3'd2:    return 20'd68259;
      3'd3:    return 20'd60606;
      3'd4:    return 20'd57204;
      3'd5:    return 20'd50963;
      3'd6:    return 20'd45403;
      3'd7:    return 20'd40449;
      default: return 20'd0;
    endcase
  endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - combinational melody lookup, zero-beat entries stretched to one beat
module melody_rom (
  input  logic [3:0] idx,
  output logic [2:0] code,
  output logic [2:0] beats
);
  import note_pkg::*;

  logic [5:0] entry;

  assign entry = MELODY[idx];
  assign code  = entry[5:3];
  assign beats = (entry[2:0] == 3'd0) ? 3'd1 : entry[2:0];

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - melody sequencer sharing the tone divisor with the manual keys
module note_scheduler #(
  parameter int BEAT_DIV = 25_000_000,
  parameter int GAP_CYC  = 2_500_000,
  parameter int SEQ_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  key,
  input  logic        play_pulse,
  input  logic        stop_pulse,
  input  logic        loop_en,
  output logic [19:0] note_div,
  output logic        busy,
  output logic [3:0]  seq_idx,
  output logic [1:0]  state
);
  import note_pkg::*;

  localparam int BW = $clog2(BEAT_DIV);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(SEQ_LEN - 1);

  seq_state_t    state_q, state_d, saved_q, saved_d;
  logic [3:0]    idx_q, idx_d, next_idx, rom_idx;
  logic [BW-1:0] beat_q, beat_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    left_q, left_d;
  logic [2:0]    rom_code, rom_beats;
  logic          last_entry;

  assign last_entry = (idx_q == LAST_IDX);
  assign next_idx   = last_entry ? 4'd0 : idx_q + 4'd1;

  // GAP is silent, so the ROM can look ahead to the next entry to reload beats_left.
  assign rom_idx = (state_q == ST_GAP) ? next_idx : idx_q;

  melody_rom u_rom (
    .idx   (rom_idx),
    .code  (rom_code),
    .beats (rom_beats)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      saved_q <= ST_PLAY;
      idx_q   <= 4'd0;
      beat_q  <= '0;
      gap_q   <= '0;
      left_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    left_d  = left_q;
    if (stop_pulse) begin
      state_d = ST_IDLE;
      idx_d   = 4'd0;
      beat_d  = '0;
      gap_d   = '0;
      left_d  = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play_pulse) begin
            state_d = ST_PLAY;
            idx_d   = 4'd0;
            left_d  = rom_beats;
            beat_d  = '0;
          end
        end
        ST_PLAY: begin
          if (play_pulse) begin
            saved_d = ST_PLAY;
            state_d = ST_PAUSE;
          end else if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            left_d = left_q - 3'd1;
            if (left_q == 3'd1) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (play_pulse) begin
            saved_d = ST_GAP;
            state_d = ST_PAUSE;
          end else if (gap_q == GAP_LAST) begin
            gap_d  = '0;
            beat_d = '0;
            if (last_entry && !loop_en) begin
              state_d = ST_IDLE;
              idx_d   = 4'd0;
              left_d  = 3'd0;
            end else begin
              state_d = ST_PLAY;
              idx_d   = next_idx;
              left_d  = rom_beats;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (play_pulse) state_d = saved_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Keys own the output whenever the sequencer is not sounding; lowest key wins.
  always_comb begin
    note_div = 20'd0;
    case (state_q)
      ST_PLAY: note_div = note_divisor(rom_code);
      ST_GAP:  note_div = 20'd0;
      default: begin
        if (key[0])      note_div = note_divisor(3'd1);
        else if (key[1]) note_div = note_divisor(3'd2);
        else if (key[2]) note_div = note_divisor(3'd3);
        else             note_div = 20'd0;
      end
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign seq_idx = idx_q;
  assign state   = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - randomized scoreboard bench for note_scheduler against a timeline model
module tb_note_scheduler;

  localparam int BEAT_DIV = 10;
  localparam int GAP_CYC  = 2;
  localparam int SEQ_LEN  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  key = 3'b000;
  logic        play_pulse = 1'b0;
  logic        stop_pulse = 1'b0;
  logic        loop_en = 1'b0;
  logic [19:0] note_div;
  logic        busy;
  logic [3:0]  seq_idx;
  logic [1:0]  state;

  note_scheduler #(.BEAT_DIV(BEAT_DIV), .GAP_CYC(GAP_CYC), .SEQ_LEN(SEQ_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .play_pulse (play_pulse),
    .stop_pulse (stop_pulse),
    .loop_en    (loop_en),
    .note_div   (note_div),
    .busy       (busy),
    .seq_idx    (seq_idx),
    .state      (state)
  );

  always #5 clk = ~clk;

  int pitch_tbl  [8]  = '{0, 76628, 68259, 60606, 57204, 50963, 45403, 40449};
  int song_code  [16] = '{3, 2, 1, 2, 3, 3, 3, 0, 2, 2, 2, 0, 3, 5, 5, 0};
  int song_beats [16] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 2, 1, 1, 1, 2, 1};

  // The whole melody unrolled into one slot per clock: playback is just a position on this tape.
  typedef struct {
    logic [19:0] div;
    logic [3:0]  idx;
    logic        gap;
  } slot_t;
  typedef struct {
    logic [19:0] div;
    logic        busy;
    logic [3:0]  idx;
    logic [1:0]  st;
  } exp_t;

  slot_t tape[$];
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    tests = 0;
  int    fails = 0;
  int    m_pos = 0;
  bit    m_active = 1'b0;
  bit    m_paused = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [19:0] key_pitch(input logic [2:0] k);
    if (k[0]) return 20'd76628;
    if (k[1]) return 20'd68259;
    if (k[2]) return 20'd60606;
    return 20'd0;
  endfunction

  task automatic build_tape();
    slot_t s;
    for (int i = 0; i < SEQ_LEN; i++) begin
      for (int c = 0; c < song_beats[i] * BEAT_DIV; c++) begin
        s.div = 20'(pitch_tbl[song_code[i]]);
        s.idx = 4'(i);
        s.gap = 1'b0;
        tape.push_back(s);
      end
      for (int c = 0; c < GAP_CYC; c++) begin
        s.div = 20'd0;
        s.idx = 4'(i);
        s.gap = 1'b1;
        tape.push_back(s);
      end
    end
  endtask

  task automatic model_edge();
    if (stop_pulse) begin
      m_active = 1'b0;
      m_paused = 1'b0;
      m_pos    = 0;
    end else if (play_pulse) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_paused = 1'b0;
        m_pos    = 0;
      end else begin
        m_paused = !m_paused;
      end
    end else if (m_active && !m_paused) begin
      m_pos++;
      if (m_pos == tape.size()) begin
        m_pos = 0;
        if (!loop_en) m_active = 1'b0;
      end
    end
  endtask

  function automatic exp_t expected();
    exp_t e;
    e.busy = m_active;
    if (!m_active) begin
      e.st  = 2'd0;
      e.idx = 4'd0;
      e.div = key_pitch(key);
    end else if (m_paused) begin
      e.st  = 2'd3;
      e.idx = tape[m_pos].idx;
      e.div = key_pitch(key);
    end else begin
      e.st  = tape[m_pos].gap ? 2'd2 : 2'd1;
      e.idx = tape[m_pos].idx;
      e.div = tape[m_pos].gap ? 20'd0 : tape[m_pos].div;
    end
    return e;
  endfunction

  // Consume one clock edge with the inputs already applied, then apply the next inputs.
  task automatic step(input logic p, input logic s, input logic l, input logic [2:0] k);
    @(posedge clk);
    model_edge();
    #1;
    play_pulse = p;
    stop_pulse = s;
    loop_en    = l;
    key        = k;
    exp_q.push_back(expected());
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("note_div", 32'(note_div), 32'(mon_e.div));
      check("busy", 32'(busy), 32'(mon_e.busy));
      check("seq_idx", 32'(seq_idx), 32'(mon_e.idx));
      check("state", 32'(state), 32'(mon_e.st));
    end
  end

  initial begin
    bit found;
    bit l_rand;
    logic [2:0] k_rand;
    build_tape();

    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_seq_idx", 32'(seq_idx), 32'd0);
    check("reset_note_div", 32'(note_div), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 0, 0, 3'b110);
    step(0, 0, 0, 3'b011);
    step(0, 0, 0, 3'b000);

    // One full pass without loop must return to IDLE.
    step(1, 0, 0, 3'b000);
    for (int i = 0; i < 240; i++) step(0, 0, 0, 3'b000);

    // Looping pass with a pause 4 cycles into entry 0.
    step(1, 0, 1, 3'b000);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3'b000);
    step(1, 0, 1, 3'b100);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 3'b100);
    step(1, 0, 1, 3'b000);
    for (int i = 0; i < 300; i++) step(0, 0, 1, 3'b000);

    // Stop coincident with play mid-note.
    step(1, 1, 1, 3'b000);
    step(0, 0, 1, 3'b001);
    step(1, 1, 0, 3'b010);
    step(0, 0, 0, 3'b000);

    k_rand = 3'b000;
    l_rand = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 7) == 0) k_rand = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) l_rand = !l_rand;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 249) == 0, l_rand, k_rand);
    end

    // Asynchronous reset in the middle of a GAP.
    step(0, 1, 1, 3'b000);
    step(1, 0, 1, 3'b000);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(0, 0, 1, 3'b000);
      if (m_active && !m_paused && tape[m_pos].gap) found = 1'b1;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL gap_search: got no GAP expected GAP within 300 cycles");
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_seq_idx", 32'(seq_idx), 32'd0);
    check("async_note_div", 32'(note_div), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #3;
    check("held_state", 32'(state), 32'd0);
    rst_n    = 1'b1;
    m_active = 1'b0;
    m_paused = 1'b0;
    m_pos    = 0;
    play_pulse = 1'b0;
    stop_pulse = 1'b0;

    step(1, 0, 0, 3'b000);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 3'b000);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
